// File: rtl/tiny_nn_core_seq_if.sv
// Handshake bundle between a command/data producer and tiny_nn_core_seq:
// command port, fp16 input word stream and result port.
interface tiny_nn_core_seq_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic        cmd_relu_i;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_relu_i, in_data_i, in_valid_i, out_ready_i,
    input  cmd_ready_o, in_ready_o, out_data_o, out_valid_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_relu_i, in_data_i, in_valid_i, out_ready_i,
    output cmd_ready_o, in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/tiny_nn_core_seq.sv
// Sequencer owning every control input of tiny_nn_core: parameter load, value shift,
// fixed 5-step compute and result handoff. Optional DOT counter: TINY_NN_SEQ_DOT_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready_o = 1)
// LOAD  | writing 8 parameter words, one-hot per word
// SHIFT | shifting 8 value words, row 0 then row 1
// COMP  | 5-step multiply/accumulate schedule
// OUT   | presenting accumulate_i until out_ready_i
module tiny_nn_core_seq #(
  parameter int ValArrayWidth  = 4,
  parameter int ValArrayHeight = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  tiny_nn_core_seq_if.slave                      bus,
  output logic [15:0]                            val_o,
  output logic [15:0]                            param_o,
  output logic [ValArrayHeight-1:0]              val_shift_o,
  output logic [ValArrayHeight*ValArrayWidth-1:0] param_write_o,
  output logic                                   mul_row_sel_o,
  output logic                                   mul_en_o,
  output logic                                   accumulate_loopback_o,
  output logic                                   accumulate_out_relu_o,
  output logic [1:0]                             accumulate_en_o,
  input  logic [15:0]                            accumulate_i,
  output logic [15:0]                            dot_count_o
);

  localparam int PW = ValArrayHeight * ValArrayWidth;

  if (ValArrayWidth != 4) begin : g_bad_width
    $error("tiny_nn_core_seq: only ValArrayWidth = 4 is supported");
  end
  if (ValArrayHeight != 2) begin : g_bad_height
    $error("tiny_nn_core_seq: only ValArrayHeight = 2 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMP,
    S_OUT
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [2:0] step_q, step_d;
  logic       relu_q, relu_d;
  logic       out_hs;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    relu_d  = relu_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          relu_d = bus.cmd_relu_i;
          k_d    = 3'd0;
          case (bus.cmd_op_i)
            2'd0:    state_d = S_LOAD;
            2'd1:    state_d = S_SHIFT;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD, S_SHIFT: begin
        if (bus.in_valid_i) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_d = (state_q == S_LOAD) ? S_IDLE : S_COMP;
            step_d  = 3'd0;
          end
        end
      end
      S_COMP: begin
        if (step_q == 3'd4) begin
          state_d = S_OUT;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      step_q  <= 3'd0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      relu_q  <= relu_d;
    end
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE);
  assign bus.in_ready_o   = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bus.out_valid_o  = (state_q == S_OUT);
  // The core holds accumulate_o while accumulate_en_o is 0, so OUT needs no local copy.
  assign bus.out_data_o   = (state_q == S_OUT) ? accumulate_i : 16'h0000;
  assign out_hs           = (state_q == S_OUT) && bus.out_ready_i;
  assign val_o            = bus.in_data_i;
  assign param_o          = bus.in_data_i;
  assign accumulate_loopback_o = 1'b0;

  always_comb begin
    val_shift_o           = '0;
    param_write_o         = '0;
    mul_en_o              = 1'b0;
    mul_row_sel_o         = 1'b0;
    accumulate_en_o       = 2'b00;
    accumulate_out_relu_o = 1'b0;
    if ((state_q == S_LOAD) && bus.in_valid_i) begin
      param_write_o = PW'(1) << k_q;
    end
    if ((state_q == S_SHIFT) && bus.in_valid_i) begin
      val_shift_o[0] = ~k_q[2];
      val_shift_o[1] = k_q[2];
    end
    if (state_q == S_COMP) begin
      case (step_q)
        3'd0: begin
          mul_en_o      = 1'b1;
          mul_row_sel_o = 1'b1;
        end
        3'd1: begin
          mul_en_o        = 1'b1;
          accumulate_en_o = 2'b01;
        end
        3'd2: begin
          accumulate_en_o = 2'b01;
          mul_row_sel_o   = 1'b1;
        end
        3'd3: accumulate_en_o = 2'b01;
        3'd4: begin
          accumulate_en_o       = 2'b10;
          accumulate_out_relu_o = relu_q;
        end
        default: accumulate_en_o = 2'b00;
      endcase
    end
  end

`ifdef TINY_NN_SEQ_DOT_COUNT_EN
  logic [15:0] dot_count_q, dot_count_d;

  always_comb begin
    dot_count_d = dot_count_q;
    if (out_hs) dot_count_d = dot_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dot_count_q <= 16'd0;
    else       dot_count_q <= dot_count_d;
  end

  assign dot_count_o = dot_count_q;
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
  assign dot_count_o   = 16'd0;
`endif

endmodule

// File: doc/tiny_nn_core_seq.md
# tiny_nn_core_seq

Control sequencer that sits directly upstream of `tiny_nn_core`. It accepts commands and a stream of fp16 words, drives all core strobes to load parameters and compute one dot product per command, and returns the core's `accumulate_o` result on a valid/ready output port. The core is never driven by hand: this block owns every core control input, and the core is always instantiated behind it.

## Interface
Parameters:
- `ValArrayWidth`, default 4: core array width. Only the value 4 is supported; an elaboration-time assertion rejects other values.
- `ValArrayHeight`, default 2: core array height. Only the value 2 is supported; an elaboration-time assertion rejects other values.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cmd_valid_i` / `cmd_ready_o`  in/out  1  command handshake.
- `cmd_op_i`  in  2  command opcode: 0 = LOAD_PARAM, 1 = DOT, 2 and 3 = reserved.
- `cmd_relu_i`  in  1  applies ReLU to the DOT result.
- `in_data_i`  in  16 (`fp_t`)  input data word.
- `in_valid_i` / `in_ready_o`  in/out  1  input data handshake.
- `out_data_o`  out  16  result word.
- `out_valid_o` / `out_ready_i`  out/in  1  result handshake.
- `val_o`, `param_o`  out  16  driven combinationally equal to `in_data_i`.
- `val_shift_o`  out  ValArrayHeight  core value-shift strobes.
- `param_write_o`  out  ValArrayHeight*ValArrayWidth  core one-hot parameter write strobes.
- `mul_row_sel_o`, `mul_en_o`, `accumulate_loopback_o`, `accumulate_out_relu_o`  out  1  core control.
- `accumulate_en_o`  out  2  core accumulate enables.
- `accumulate_i`  in  16  connected to the core's `accumulate_o`.
- `dot_count_o`  out  16  count of completed DOT results (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SHIFT, COMP, OUT. Reset state is IDLE.
- `cmd_ready_o` is 1 only in IDLE. `in_ready_o` is 1 only in LOAD and SHIFT.
- A command is accepted when `cmd_valid_i & cmd_ready_o`. The block latches `cmd_relu_i` and moves to:
  - LOAD for op 0;
  - SHIFT for op 1;
  - nowhere for ops 2 and 3: the command is consumed and the FSM stays in IDLE.
- Word counter `k` has 3 bits and is cleared on command accept. It increments on each input handshake.
- LOAD:
  - For each handshake, `param_write_o = 1 << k`.
  - Bit index k corresponds to core cell x = k/2, y = k%2.
  - After the handshake with k = 7, go to IDLE.
- SHIFT:
  - For each handshake, `val_shift_o[k/4] = 1`.
  - Words 0–3 fill row 0 and words 4–7 fill row 1. The first word of each row ends at x = 0.
  - After the handshake with k = 7, go to COMP with step = 0.
- COMP: a fixed 5-step schedule.
  - Step 0: `mul_en_o=1`, `mul_row_sel_o=1`.
  - Step 1: `mul_en_o=1`, `mul_row_sel_o=0`, `accumulate_en_o=01`.
  - Step 2: `accumulate_en_o=01`, `mul_row_sel_o=1`.
  - Step 3: `accumulate_en_o=01`, `mul_row_sel_o=0`.
  - Step 4: `accumulate_en_o=10`, `accumulate_out_relu_o` = latched relu. Then go to OUT.
- OUT:
  - `out_valid_o = 1` and `out_data_o = accumulate_i`. The core holds this value because `accumulate_en_o` is 0.
  - On `out_ready_i` go to IDLE.
- `accumulate_loopback_o` is always 0.
- All core strobes are decoded from state only. Every strobe is 0 outside the case in which it is listed above.
- Strobes that depend on an input handshake are gated by `in_valid_i`. A cycle with `in_valid_i = 0` produces no strobe and does not advance `k`.

## Timing
- Reset: the block is in IDLE one cycle after `rst_i` is sampled high.
  - In that cycle `cmd_ready_o = 1`, and all other outputs, strobes, `k`, step and `dot_count_o` are 0.
  - Reset during any state aborts the operation. A partially loaded core array is left as-is.
- Latency: if the last DOT word is accepted in cycle T, COMP steps 0–4 occupy cycles T+1 to T+5 and `out_valid_o` rises in cycle T+6.
- Throughput: a DOT command with no input gaps and no backpressure takes 1 cycle for the command, 8 cycles for words, 5 for COMP and at least 1 for OUT. A new command can be accepted in the cycle after the OUT handshake.
- Backpressure: `out_valid_o` and `out_data_o` hold stable until the handshake. No command is accepted while in OUT.
- Commands and data are never accepted in the same cycle.

## Configuration
- `TINY_NN_SEQ_DOT_COUNT_EN` defined:
  - `dot_count_o` is a 16-bit register. It increments on each OUT handshake and wraps from 0xFFFF to 0.
  - It is cleared by reset.
- Macro undefined: `dot_count_o` is tied to 0 and no counter flops exist.

## Test plan
All scenarios run with `tiny_nn_core` connected.
- Reset: assert `rst_i` mid-SHIFT at k = 3 → next cycle IDLE, `cmd_ready_o=1`, `in_ready_o=0`, all strobes 0, `dot_count_o=0`.
- LOAD_PARAM with 8 words of 0x3C00, `in_valid_i` low every other cycle → `param_write_o` sequence 0x01, 0x02, …, 0x80, with no strobe in gap cycles; IDLE after the 8th word.
- DOT, params 0x3C00, values 0x3C00, relu=0 → `out_valid_o` at T+6 with `out_data_o=0x4800` (8.0); `dot_count_o=1` with the macro, 0 without.
- DOT, values 0xBC00: relu=0 → `out_data_o=0xC800`; relu=1 → `out_data_o=0x0000`.
- Backpressure: hold `out_ready_i=0` for 10 cycles → `out_valid_o` and `out_data_o` stable and `cmd_ready_o=0` throughout; after the handshake, IDLE on the next cycle.
- Reserved op 3 → accepted in 1 cycle with no strobes; FSM stays IDLE and `in_ready_o` stays 0.
